// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared adder types, widths and round-robin pick function
package adder_pkg;

    localparam int ADD_W    = 32;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = $clog2(MAX_REQ);

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
        logic             cin;
        logic             sub;
    } add_req_t;

    typedef struct packed {
        logic [ADD_W-1:0] sum;
        logic             cout;
        logic             ovf;
    } add_rsp_t;

    // One-hot grant: first valid bit at or after ptr, wrapping modulo num_req.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        num_req
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (ptr + i) % num_req;
            if (i < num_req && !found && valid[idx[MAX_ID_W-1:0]]) begin
                grant[idx[MAX_ID_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/adder_bk_32b.sv
// rtl/adder_bk_32b.sv - combinational 32-bit add/subtract around the Brent-Kung carry tree
module adder_bk_32b
    import adder_pkg::*;
(
    input  add_req_t req_i,
    output add_rsp_t rsp_o
);

    logic [ADD_W-1:0] b_eff;
    logic [ADD_W-1:0] p;
    logic [ADD_W-1:0] g;
    logic [ADD_W-1:0] c;
    logic             c_in;

    // Subtract is a + ~b + 1; a set cin in sub mode turns that into a borrow-in.
    always_comb begin
        b_eff = req_i.sub ? ~req_i.b : req_i.b;
        c_in  = req_i.cin ^ req_i.sub;
        p     = req_i.a ^ b_eff;
        g     = req_i.a & b_eff;
        g[0]  = g[0] | (p[0] & c_in);
    end

    carry_tree_bk_32b u_carry_tree (
        .g_i (g),
        .p_i (p),
        .c_o (c)
    );

    assign rsp_o.sum  = p ^ {c[ADD_W-2:0], c_in};
    assign rsp_o.cout = c[ADD_W-1] ^ req_i.sub;
    assign rsp_o.ovf  = c[ADD_W-1] ^ c[ADD_W-2];

endmodule

// File: rtl/carry_tree_bk_32b.sv
// rtl/carry_tree_bk_32b.sv - 32-bit Brent-Kung prefix carry tree, c_o[i] = carry out of bit i
module carry_tree_bk_32b (
    input  logic [31:0] g_i,
    input  logic [31:0] p_i,
    output logic [31:0] c_o
);

    logic [31:0] gg;
    logic [31:0] pp;

    always_comb begin
        gg = g_i;
        pp = p_i;
        // Up-sweep: node i (i+1 a multiple of 2*span) absorbs the group below it.
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if ((i % (2 << l)) == ((2 << l) - 1)) begin
                    gg[i] = gg[i] | (pp[i] & gg[(i + 32 - (1 << l)) % 32]);
                    pp[i] = pp[i] & pp[(i + 32 - (1 << l)) % 32];
                end
            end
        end
        // Down-sweep: fill the remaining positions from the finished prefixes.
        for (int l = 3; l >= 0; l--) begin
            for (int i = 0; i < 32; i++) begin
                if (i >= 3 * (1 << l) - 1 && ((i + 1) % (2 << l)) == (1 << l)) begin
                    gg[i] = gg[i] | (pp[i] & gg[(i + 32 - (1 << l)) % 32]);
                end
            end
        end
        c_o = gg;
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin shared adder with one registered, id-tagged response
module adder_rr_arbiter
    import adder_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_a_i,
    input  logic [NUM_REQ*32-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]    req_cin_i,
    input  logic [NUM_REQ-1:0]    req_sub_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [31:0]           rsp_sum_o,
    output logic                  rsp_cout_o,
    output logic                  rsp_ovf_o
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] grant_ext;
    logic               any_grant;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;
    logic               handshake;
    add_req_t           sel_req;
    add_rsp_t           add_rsp;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    add_rsp_t           rsp_q, rsp_d;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid_i;
        grant_ext                = rr_pick(valid_ext, 32'(ptr_q), NUM_REQ);
        any_grant                = 1'b0;
        grant_idx                = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (grant_ext[k]) begin
                any_grant = 1'b1;
                grant_idx = ID_W'(k);
            end
        end
        // Single output register: a new result may only land once the old one leaves.
        accept    = !rsp_valid_q || rsp_ready_i;
        handshake = !rst_i && accept && any_grant;
        req_ready_o = '0;
        if (handshake) begin
            req_ready_o[grant_idx] = 1'b1;
        end
        sel_req.a   = req_a_i[32*grant_idx +: 32];
        sel_req.b   = req_b_i[32*grant_idx +: 32];
        sel_req.cin = req_cin_i[grant_idx];
        sel_req.sub = req_sub_i[grant_idx];
    end

    adder_bk_32b u_adder (
        .req_i (sel_req),
        .rsp_o (add_rsp)
    );

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_d       = rsp_q;
        if (handshake) begin
            ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_d       = add_rsp;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q       <= rsp_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_sum_o   = rsp_q.sum;
    assign rsp_cout_o  = rsp_q.cout;
    assign rsp_ovf_o   = rsp_q.ovf;

endmodule
